// File: rtl/ads7254_pkg.sv
// Shared definitions for the ADS7254 serial link: default frame geometry
// and the device-side frame state encoding.
package ads7254_pkg;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_CFG_W     = 16;
  localparam int DEF_FRAME_LEN = 32;
  localparam int DEF_LEAD_CLKS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } ads_state_e;

endpackage

// File: rtl/ads7254_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the last stage and one extra delay flop.
module ads7254_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Move the pin through the synchronizer chain; reset presets the idle level
  // so no spurious edge appears when reset is released with the pin idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/ads7254_emu.sv
// Device-side emulator of the ADS7254 dual-channel ADC: serializes two
// channel words on SDOA/SDOB and captures the host's SDI command word.
module ads7254_emu
  import ads7254_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEAD_CLKS   = DEF_LEAD_CLKS,
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int CFG_W       = DEF_CFG_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK_100,
  input  logic              iRST_n,
  input  logic              iSCLK,
  input  logic              iCS_n,
  input  logic              iSDI,
  input  logic [DATA_W-1:0] idata_ch_A,
  input  logic [DATA_W-1:0] idata_ch_B,
  output logic              oSDOA,
  output logic              oSDOB,
  output logic [CFG_W-1:0]  oconfig,
  output logic              oconfig_valid,
  output logic              oframe_done,
  output logic              oabort,
  output logic              obusy
);

  localparam int FC_W = $clog2(FRAME_LEN + 1);
  localparam int RC_W = $clog2(CFG_W + 1);
  localparam int BC_W = $clog2(DATA_W + 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;

  ads7254_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk_i(iCLK_100), .rst_ni(iRST_n), .async_i(iSCLK),
    .sync_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  ads7254_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(iCLK_100), .rst_ni(iRST_n), .async_i(iCS_n),
    .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  ads7254_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk_i(iCLK_100), .rst_ni(iRST_n), .async_i(iSDI),
    .sync_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
  );

  ads_state_e        state_q;
  logic [DATA_W-1:0] sh_a_q, sh_b_q;
  logic [CFG_W-1:0]  cfg_sr_q, cfg_q;
  logic [FC_W-1:0]   fall_cnt_q, fall_cnt_d;
  logic [RC_W-1:0]   rise_cnt_q, rise_cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              sdoa_q, sdob_q, cfg_valid_q, frame_done_q, abort_q, busy_q;

  assign fall_cnt_d = fall_cnt_q + FC_W'(1);
  assign rise_cnt_d = rise_cnt_q + RC_W'(1);
  assign bit_cnt_d  = bit_cnt_q + BC_W'(1);

  // Frame sequencer: shadow load on CS_n fall, lead-in, serialization,
  // SDI capture, and frame close with CS_n rise taking priority over SCLK.
  always_ff @(posedge iCLK_100) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      cfg_sr_q     <= '0;
      cfg_q        <= '0;
      fall_cnt_q   <= '0;
      rise_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      sdoa_q       <= 1'b0;
      sdob_q       <= 1'b0;
      cfg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cfg_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            sh_a_q     <= idata_ch_A;
            sh_b_q     <= idata_ch_B;
            fall_cnt_q <= '0;
            rise_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_LEAD;
          end
        end
        default: begin
          if (cs_rise) begin
            if (fall_cnt_q == FC_W'(FRAME_LEN)) frame_done_q <= 1'b1;
            else                                abort_q      <= 1'b1;
            if (rise_cnt_q == RC_W'(CFG_W)) begin
              cfg_q       <= cfg_sr_q;
              cfg_valid_q <= 1'b1;
            end
            sdoa_q  <= 1'b0;
            sdob_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!cs_s) begin
            if (sclk_rise && (rise_cnt_q < RC_W'(CFG_W))) begin
              cfg_sr_q   <= {cfg_sr_q[CFG_W-2:0], sdi_s};
              rise_cnt_q <= rise_cnt_d;
            end
            if (sclk_fall) begin
              if (fall_cnt_q < FC_W'(FRAME_LEN)) fall_cnt_q <= fall_cnt_d;
              case (state_q)
                ST_LEAD: begin
                  if (fall_cnt_q == FC_W'(LEAD_CLKS - 1)) begin
                    sdoa_q    <= sh_a_q[DATA_W-1];
                    sdob_q    <= sh_b_q[DATA_W-1];
                    sh_a_q    <= sh_a_q << 1;
                    sh_b_q    <= sh_b_q << 1;
                    bit_cnt_q <= BC_W'(1);
                    state_q   <= ST_SHIFT;
                  end
                end
                ST_SHIFT: begin
                  if (bit_cnt_q == BC_W'(DATA_W)) begin
                    sdoa_q  <= 1'b0;
                    sdob_q  <= 1'b0;
                    state_q <= ST_TAIL;
                  end else begin
                    sdoa_q    <= sh_a_q[DATA_W-1];
                    sdob_q    <= sh_b_q[DATA_W-1];
                    sh_a_q    <= sh_a_q << 1;
                    sh_b_q    <= sh_b_q << 1;
                    bit_cnt_q <= bit_cnt_d;
                  end
                end
                default: begin
                  sdoa_q <= 1'b0;
                  sdob_q <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign oSDOA         = sdoa_q;
  assign oSDOB         = sdob_q;
  assign oconfig       = cfg_q;
  assign oconfig_valid = cfg_valid_q;
  assign oframe_done   = frame_done_q;
  assign oabort        = abort_q;
  assign obusy         = busy_q;

endmodule

// File: tb/tb_ads7254_emu.sv
// Directed bench for ads7254_emu: a host model drives CS_n/SCLK/SDI, decodes
// SDOA/SDOB, and a scoreboard checks end-of-frame pulses and the config word.
module tb_ads7254_emu;

  logic        iCLK_100   = 1'b0;
  logic        iRST_n     = 1'b0;
  logic        iSCLK      = 1'b1;
  logic        iCS_n      = 1'b1;
  logic        iSDI       = 1'b0;
  logic [11:0] idata_ch_A = '0;
  logic [11:0] idata_ch_B = '0;
  logic        oSDOA, oSDOB, oconfig_valid, oframe_done, oabort, obusy;
  logic [15:0] oconfig;

  ads7254_emu dut (
    .iCLK_100(iCLK_100), .iRST_n(iRST_n), .iSCLK(iSCLK), .iCS_n(iCS_n), .iSDI(iSDI),
    .idata_ch_A(idata_ch_A), .idata_ch_B(idata_ch_B),
    .oSDOA(oSDOA), .oSDOB(oSDOB), .oconfig(oconfig), .oconfig_valid(oconfig_valid),
    .oframe_done(oframe_done), .oabort(oabort), .obusy(obusy)
  );

  always #5 iCLK_100 = ~iCLK_100;

  typedef struct packed {
    logic        done;
    logic        abort;
    logic        cfgv;
    logic [15:0] cfg;
  } end_t;

  end_t        end_q[$];
  logic [23:0] word_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        prev_pulse = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_end(input logic d, input logic a, input logic c, input logic [15:0] cfg);
    end_t e;
    e.done  = d;
    e.abort = a;
    e.cfgv  = c;
    e.cfg   = cfg;
    end_q.push_back(e);
  endtask

  // End-of-frame monitor: every pulse cycle pops one expectation.
  always @(negedge iCLK_100) begin
    if (oframe_done || oabort || oconfig_valid) begin
      if (end_q.size() == 0) begin
        chk("unexpected_pulse", {oframe_done, oabort, oconfig_valid}, 3'b000);
      end else begin
        chk("frame_done", oframe_done, end_q[0].done);
        chk("abort", oabort, end_q[0].abort);
        chk("config_valid", oconfig_valid, end_q[0].cfgv);
        if (end_q[0].cfgv) chk("config", oconfig, end_q[0].cfg);
        void'(end_q.pop_front());
      end
      if (prev_pulse) chk("pulse_width", 1, 0);
    end
    prev_pulse <= oframe_done | oabort | oconfig_valid;
  end

  // Host model: one frame of nfalls SCLK falls, sampling SDO just before each rise.
  task automatic frame(input logic [11:0] a, input logic [11:0] b, input logic [15:0] sdi,
                       input int nfalls, input int half, input bit coincide, input bit release_cs,
                       input int chg_at, input logic [11:0] chg_a,
                       output logic [11:0] ga, output logic [11:0] gb,
                       output logic [1:0] z1, output logic [1:0] z14, output logic busy);
    idata_ch_A = a;
    idata_ch_B = b;
    ga = '0; gb = '0; z1 = 2'b11; z14 = 2'b11; busy = 1'b0;
    #(2 * half);
    iCS_n = 1'b0;
    #(2 * half);
    for (int k = 1; k <= nfalls; k++) begin
      iSCLK = 1'b0;
      iSDI  = (k <= 16) ? sdi[16-k] : 1'b0;
      if (coincide && k == nfalls) iCS_n = 1'b1;
      if (k == chg_at) idata_ch_A = chg_a;
      #(half);
      if (k == 1) begin
        z1   = {oSDOA, oSDOB};
        busy = obusy;
      end
      if (k == 14) z14 = {oSDOA, oSDOB};
      if (k >= 2 && k <= 13) begin
        ga = {ga[10:0], oSDOA};
        gb = {gb[10:0], oSDOB};
      end
      iSCLK = 1'b1;
      #(half);
    end
    if (release_cs) iCS_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (end_q.size() != 0 && n < 50) begin
      @(negedge iCLK_100);
      n++;
    end
    chk(tag, end_q.size(), 0);
    repeat (3) @(negedge iCLK_100);
  endtask

  task automatic check_words(input string tag, input logic [11:0] ga, input logic [11:0] gb,
                             input logic [1:0] z1, input logic [1:0] z14, input logic busy);
    logic [23:0] w;
    w = word_q.pop_front();
    chk({tag, "_sdoa_word"}, ga, w[23:12]);
    chk({tag, "_sdob_word"}, gb, w[11:0]);
    chk({tag, "_lead_zero"}, z1, 2'b00);
    chk({tag, "_tail_zero"}, z14, 2'b00);
    chk({tag, "_busy_mid"}, busy, 1'b1);
  endtask

  initial begin
    logic [11:0] ga, gb;
    logic [1:0]  z1, z14;
    logic        bz;
    logic [15:0] exp_cfg;

    // Reset state
    repeat (3) @(negedge iCLK_100);
    chk("rst_sdoa", oSDOA, 1'b0);
    chk("rst_sdob", oSDOB, 1'b0);
    chk("rst_config", oconfig, 16'h0000);
    chk("rst_pulses", {oframe_done, oabort, oconfig_valid}, 3'b000);
    chk("rst_busy", obusy, 1'b0);
    iRST_n = 1'b1;
    exp_cfg = 16'h0000;
    repeat (5) @(negedge iCLK_100);

    // Full frame at ~8 MHz with command word 0x8311
    word_q.push_back({12'hA5C, 12'h3F0});
    push_end(1'b1, 1'b0, 1'b1, 16'h8311);
    exp_cfg = 16'h8311;
    frame(12'hA5C, 12'h3F0, 16'h8311, 32, 60, 1'b0, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    check_words("f1", ga, gb, z1, z14, bz);
    drain("f1_drain");
    chk("f1_busy_after", obusy, 1'b0);
    chk("f1_config_hold", oconfig, exp_cfg);

    // Premature CS_n rise after 10 falls
    push_end(1'b0, 1'b1, 1'b0, 16'h0000);
    frame(12'h5A3, 12'hC0F, 16'h1234, 10, 60, 1'b0, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    drain("ab_drain");
    chk("ab_config_unchanged", oconfig, exp_cfg);
    chk("ab_sdo_zero", {oSDOA, oSDOB}, 2'b00);
    chk("ab_busy_after", obusy, 1'b0);

    // Next full frame after the abort
    word_q.push_back({12'h5A3, 12'hC0F});
    push_end(1'b1, 1'b0, 1'b1, 16'h4C7E);
    exp_cfg = 16'h4C7E;
    frame(12'h5A3, 12'hC0F, 16'h4C7E, 32, 60, 1'b0, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    check_words("f2", ga, gb, z1, z14, bz);
    drain("f2_drain");

    // Channel A input changes mid-frame; shadow value must be sent
    word_q.push_back({12'h001, 12'h800});
    push_end(1'b1, 1'b0, 1'b1, 16'h0001);
    exp_cfg = 16'h0001;
    frame(12'h001, 12'h800, 16'h0001, 32, 60, 1'b0, 1'b1, 5, 12'hFFF, ga, gb, z1, z14, bz);
    check_words("chg", ga, gb, z1, z14, bz);
    drain("chg_drain");

    // Reset at fall 8; CS_n released while reset is held, so nothing resumes
    frame(12'h7E1, 12'h18C, 16'hFFFF, 8, 60, 1'b0, 1'b0, 0, 12'h000, ga, gb, z1, z14, bz);
    chk("pre_rst_sdoa", oSDOA, 1'b1);
    chk("pre_rst_busy", obusy, 1'b1);
    @(negedge iCLK_100);
    iRST_n = 1'b0;
    iCS_n  = 1'b1;
    @(negedge iCLK_100);
    iRST_n = 1'b1;
    exp_cfg = 16'h0000;
    chk("mid_rst_sdo", {oSDOA, oSDOB}, 2'b00);
    chk("mid_rst_config", oconfig, 16'h0000);
    chk("mid_rst_busy", obusy, 1'b0);
    chk("mid_rst_pulses", {oframe_done, oabort, oconfig_valid}, 3'b000);
    repeat (30) @(negedge iCLK_100);
    chk("mid_rst_busy_later", obusy, 1'b0);

    // Frame after the reset
    word_q.push_back({12'h2B6, 12'hD49});
    push_end(1'b1, 1'b0, 1'b1, 16'hBEEF);
    exp_cfg = 16'hBEEF;
    frame(12'h2B6, 12'hD49, 16'hBEEF, 32, 60, 1'b0, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    check_words("f3", ga, gb, z1, z14, bz);
    drain("f3_drain");

    // 16 MHz: CS_n rise lands with the 32nd fall, so only 31 falls count
    push_end(1'b0, 1'b1, 1'b1, 16'h5AA5);
    exp_cfg = 16'h5AA5;
    frame(12'h9C3, 12'h36C, 16'h5AA5, 32, 32, 1'b1, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    drain("fast_coinc_drain");
    chk("fast_coinc_sdo_zero", {oSDOA, oSDOB}, 2'b00);
    chk("fast_coinc_busy", obusy, 1'b0);

    // 16 MHz complete frame
    word_q.push_back({12'hE17, 12'h0C8});
    push_end(1'b1, 1'b0, 1'b1, 16'h0F0F);
    exp_cfg = 16'h0F0F;
    frame(12'hE17, 12'h0C8, 16'h0F0F, 32, 32, 1'b0, 1'b1, 0, 12'h000, ga, gb, z1, z14, bz);
    check_words("fast", ga, gb, z1, z14, bz);
    drain("fast_drain");
    chk("final_config", oconfig, exp_cfg);

    chk("scoreboard_empty", end_q.size() + word_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ads7254_emu.md
Name: ads7254_emu

Overview:
- Synthesizable emulator of the ADS7254 dual-channel serial ADC, i.e. the device end of the link that the ADS7254 host interface drives.
- Samples the host's oCS_n/oCLK/oSDI lines on the 100 MHz fabric clock and serializes two 12-bit channel words onto SDOA/SDOB.
- Captures the host's SDI command word for inspection.
- Used for hardware-in-loop loopback of the ADS7254 host block and as a bench responder.

Parameters:
- DATA_W, 12: channel word width, MSB first on SDO.
- LEAD_CLKS, 2: SCLK falling edges after CS_n fall before the MSB is driven.
- FRAME_LEN, 32: SCLK falling edges constituting a complete frame.
- CFG_W, 16: SDI command bits captured per frame.
- SYNC_STAGES, 2: synchronizer depth on iSCLK/iCS_n/iSDI (minimum 2).

Ports:
- iCLK_100  in  1  fabric clock, 100 MHz; all logic on rising edge.
- iRST_n  in  1  synchronous reset, active-low.
- iSCLK  in  1  serial clock from host (async to iCLK_100).
- iCS_n  in  1  chip select from host, active-low (async).
- iSDI  in  1  host command data (async).
- idata_ch_A  in  DATA_W  word to return on SDOA.
- idata_ch_B  in  DATA_W  word to return on SDOB.
- oSDOA  out  1  serial data channel A.
- oSDOB  out  1  serial data channel B.
- oconfig  out  CFG_W  last complete SDI command word.
- oconfig_valid  out  1  1-cycle pulse when oconfig updates.
- oframe_done  out  1  1-cycle pulse on a complete frame end.
- oabort  out  1  1-cycle pulse on a premature CS_n rise.
- obusy  out  1  high while a frame is active.

Behaviour:
- Reset values (iRST_n low at a rising edge): oSDOA = oSDOB = 0, oconfig = 0, all pulses 0, obusy = 0, state IDLE, counters 0, synchronizer stages preset to idle levels (SCLK = 1, CS_n = 1, SDI = 0).
- Synchronizer and edge detection:
  - iSCLK, iCS_n and iSDI each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one further delay flop.
  - Timing constraint: SCLK high and low times must each be ≥ 3 iCLK_100 periods (SCLK ≤ 16 MHz).
- FSM states: IDLE, LEAD, SHIFT, TAIL.
  - IDLE: on CS_n fall, latch idata_ch_A/B into shadow registers, clear the fall counter and the rise counter, obusy = 1, go to LEAD.
  - LEAD: count SCLK falls. On fall number LEAD_CLKS, drive the MSBs onto SDOA/SDOB and go to SHIFT.
  - SHIFT: each SCLK fall drives the next bit. After the LSB has been driven, the next fall drives 0 and the FSM goes to TAIL.
  - TAIL: SDO held at 0 and falls still counted. Fall count saturates at FRAME_LEN.
- SDO timing: updates in the iCLK_100 cycle after the fall is detected, i.e. SYNC_STAGES+1 cycles after the pin edge. Host samples on the following SCLK edge.
- SDI capture: on each SCLK rise while CS_n is low, and while the rise count is < CFG_W, shift iSDI into a CFG_W shift register (MSB first). Rise count saturates at CFG_W.
- CS_n rise, in any non-IDLE state:
  - Fall count == FRAME_LEN: oframe_done pulses.
  - Otherwise: oabort pulses.
  - In both cases: if rise count == CFG_W, load oconfig and pulse oconfig_valid in the same cycle. Then SDO = 0, obusy = 0, return to IDLE.
- Simultaneous events: CS_n rise takes priority over an SCLK edge detected in the same cycle. An SCLK edge while CS_n is high is ignored.
- idata changes mid-frame have no effect; the shadow registers are only loaded at CS_n fall.
- Synchronous reset mid-frame forces the reset state immediately and raises no pulse. A frame already in progress is not recovered; the next CS_n fall starts fresh.

Decomposition:
- Package ads7254_pkg: DATA_W, CFG_W, FRAME_LEN, LEAD_CLKS defaults and the state enumeration, shared with the host interface.
- One sub-module, ads7254_sync_edge: N-stage synchronizer with rise/fall pulse outputs, instantiated once per async input.

Test Plan:
- Reset, then idata_ch_A = 0xA5C, idata_ch_B = 0x3F0, full 32-clock frame at 8 MHz SCLK -> host decodes 0xA5C/0x3F0; bits appear after fall 2; oframe_done = 1 for one cycle; obusy is 0 afterward.
- SDI = 0x8311 clocked MSB first over the first 16 rises -> on CS_n rise, oconfig = 0x8311 and oconfig_valid pulses once.
- CS_n raised after 10 falls -> oabort pulses, oframe_done stays 0, oconfig unchanged, SDO = 0. The next full frame returns the correct words.
- idata_ch_A changed from 0x001 to 0xFFF at fall 5 -> SDOA still serializes 0x001.
- iRST_n low for one cycle at fall 8 -> all outputs at reset values, no pulse. The following frame delivers the correct data.
- SCLK at the 16 MHz limit with CS_n rise coincident with the last SCLK fall -> frame ends via the CS_n priority path; oabort or oframe_done follows the fall count (31 -> oabort).
